// File: rtl/runlight_pkg.sv
// Shared constants and helpers for the running-light pattern generator.
package runlight_pkg;

    localparam logic [2:0] M_FILL = 3'd0;
    localparam logic [2:0] M_CONV = 3'd1;
    localparam logic [2:0] M_HALF = 3'd2;
    localparam logic [2:0] M_PAIR = 3'd3;
    localparam logic [2:0] M_OFF  = 3'd4;

    // Number of steps in one full sequence of a pattern; codes 5..7 run as FILL.
    function automatic int unsigned pat_len(input logic [2:0] mode, input int unsigned n);
        case (mode)
            M_CONV:  return n;
            M_HALF:  return n + 1;
            M_PAIR:  return n / 2 + 1;
            M_OFF:   return 1;
            default: return 2 * n;
        endcase
    endfunction

endpackage

// File: rtl/runlight_tick.sv
// Step-rate prescaler: one tick every div+1 enabled cycles, cleared on restart.
module runlight_tick
    import runlight_pkg::*;
#(
    parameter int DIV_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // A shrinking div leaves cnt above it; cnt then wraps and meets div again.
    assign tick = en && (cnt == div);

    // Count enabled cycles, restart from zero on tick or pattern restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/runlight_gen.sv
// Running-light pattern generator: mode capture, step sequencing and LED register.
module runlight_gen
    import runlight_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIV_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       S,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             dir,
    input  logic             oneshot,
    output logic [N-1:0]     Y,
    output logic             done,
    output logic             busy
);

    localparam int SW  = $clog2(2 * N);
    localparam int SW1 = SW + 1;

    // Index arithmetic is done one bit wider than step so N-1-s etc. never wrap.
    localparam logic [SW:0]  N_W    = SW1'(N);
    localparam logic [SW:0]  HALF_W = SW1'(N / 2);
    localparam logic [SW:0]  ONE_W  = SW1'(1);
    localparam logic [N-1:0] ONE    = N'(1);
    localparam logic [N-1:0] UPPER  = {{(N/2){1'b1}}, {(N/2){1'b0}}};
    localparam logic [N-1:0] LOWER  = {{(N/2){1'b0}}, {(N/2){1'b1}}};

    logic [2:0]    mode_q;
    logic [SW-1:0] step;
    logic          stopped;
    logic          tick;
    logic          restart;
    logic          last;
    logic [SW-1:0] step_last;

    // One-hot mask for logical bit k, mirrored when d is set.
    function automatic logic [N-1:0] bit_at(input logic [SW:0] k, input logic d);
        logic [SW:0] m;
        m = d ? (N_W - ONE_W - k) : k;
        return ONE << m;
    endfunction

    // LED value after applying step s of mode m to the current value y.
    function automatic logic [N-1:0] next_pattern(input logic [N-1:0] y,
                                                  input logic [SW-1:0] s,
                                                  input logic [2:0] m,
                                                  input logic d);
        logic [N-1:0] r;
        logic [SW:0]  se;
        logic [SW:0]  j;
        r  = y;
        se = {1'b0, s};
        j  = '0;
        case (m)
            M_CONV: begin
                if (se < HALF_W) begin
                    r = r | bit_at(N_W - ONE_W - se, d) | bit_at(se, d);
                end else begin
                    j = se - HALF_W;
                    r = r & ~(bit_at(j, d) | bit_at(N_W - ONE_W - j, d));
                end
            end
            M_HALF: begin
                if (se == '0)
                    r = d ? LOWER : UPPER;
                else if (se <= HALF_W)
                    r = r & ~bit_at(N_W - se, d);
            end
            M_PAIR: begin
                if (se < HALF_W)
                    r = r | bit_at(se << 1, d) | bit_at((se << 1) + ONE_W, d);
                else
                    r = '0;
            end
            M_OFF: r = '0;
            default: begin
                if (se < N_W)
                    r = r | bit_at(N_W - ONE_W - se, d);
                else
                    r = r & ~bit_at(N_W - ONE_W - (se - N_W), d);
            end
        endcase
        return r;
    endfunction

    assign restart   = (S != mode_q);
    assign step_last = SW'(pat_len(mode_q, N) - 1);
    assign last      = (step == step_last);
    assign busy      = !stopped && (mode_q != M_OFF);

    runlight_tick #(.DIV_W(DIV_W)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (restart),
        .div   (div),
        .tick  (tick)
    );

    // Pattern sequencer: restart beats tick; OFF parks at zero; ticks advance the step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= M_OFF;
            step    <= '0;
            stopped <= 1'b0;
            Y       <= '0;
            done    <= 1'b0;
        end else begin
            mode_q <= S;
            if (restart) begin
                step    <= '0;
                Y       <= '0;
                stopped <= 1'b0;
                done    <= 1'b0;
            end else if (mode_q == M_OFF) begin
                step <= '0;
                Y    <= '0;
                done <= 1'b0;
            end else if (tick && !stopped) begin
                Y    <= next_pattern(Y, step, mode_q, dir);
                done <= last;
                step <= last ? '0 : step + 1'b1;
                if (last && oneshot)
                    stopped <= 1'b1;
            end else begin
                done <= 1'b0;
            end
        end
    end

endmodule
